// File: rtl/gesture_pkg.sv
// Shared types and helpers for the gesture front end; gesture_t is also used by the wave display.
package gesture_pkg;

  typedef enum logic [2:0] {
    G_NONE  = 3'd0,
    G_LEFT  = 3'd1,
    G_RIGHT = 3'd2,
    G_UP    = 3'd3,
    G_DOWN  = 3'd4
  } gesture_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    HOLD     = 2'd1,
    COOLDOWN = 2'd2
  } fsm_t;

  function automatic int unsigned ms_to_cyc(input int unsigned clk_fre, input int unsigned ms);
    return clk_fre / 1000 * ms;
  endfunction

  // Index 0 (left) wins, then right, up, down.
  function automatic gesture_t gesture_from_events(input logic [3:0] ev);
    if (ev[0])      return G_LEFT;
    else if (ev[1]) return G_RIGHT;
    else if (ev[2]) return G_UP;
    else if (ev[3]) return G_DOWN;
    else            return G_NONE;
  endfunction

endpackage

// File: rtl/gesture_encoder_debounce.sv
// btn_debounce: two-flop synchroniser, polarity normalisation, debounce counter and press edge.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYC   = 500000,
  parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic level,
  output logic rise
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYC + 1);

  logic          sync1_q, sync2_q;
  logic          pressed;
  logic          level_q, rise_q;
  logic [CW-1:0] cnt_q;

  assign pressed = sync2_q ^ BTN_ACTIVE_LOW;

  // Synchroniser resets to the pin's idle (not pressed) level.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q <= BTN_ACTIVE_LOW;
      sync2_q <= BTN_ACTIVE_LOW;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      rise_q  <= 1'b0;
      if (pressed == level_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CW'(DEBOUNCE_CYC)) begin
        level_q <= ~level_q;
        rise_q  <= ~level_q;
        cnt_q   <= '0;
      end else begin
        cnt_q <= cnt_q + CW'(1);
      end
    end
  end

  assign level = level_q;
  assign rise  = rise_q;

endmodule

// File: rtl/gesture_encoder.sv
// Four debounced direction buttons -> prioritised gesture code held for one animation plus cooldown.
// Optional GESTURE_AUTOREPEAT_EN: a still-pressed button retriggers whenever the FSM is idle.
module gesture_encoder
  import gesture_pkg::*;
#(
  parameter int unsigned CLK_FRE        = 50000000,
  parameter int unsigned DEBOUNCE_MS    = 10,
  parameter int unsigned HOLD_MS        = 1400,
  parameter int unsigned COOLDOWN_MS    = 200,
  parameter bit          BTN_ACTIVE_LOW = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] btn,
  output logic [2:0] signal,
  output logic       start,
  output logic       busy
);

  localparam int unsigned DEBOUNCE_CYC = ms_to_cyc(CLK_FRE, DEBOUNCE_MS);
  localparam int unsigned HOLD_CYC     = ms_to_cyc(CLK_FRE, HOLD_MS);
  localparam int unsigned COOLDOWN_CYC = ms_to_cyc(CLK_FRE, COOLDOWN_MS);
  localparam int unsigned TMAX         = (HOLD_CYC > COOLDOWN_CYC) ? HOLD_CYC : COOLDOWN_CYC;
  localparam int unsigned TW           = $clog2(TMAX + 1);
  localparam int unsigned CD_LOAD      = (COOLDOWN_CYC > 0) ? COOLDOWN_CYC - 1 : 0;

`ifdef GESTURE_AUTOREPEAT_EN
  localparam bit AUTOREPEAT = 1'b1;
`else
  localparam bit AUTOREPEAT = 1'b0;
`endif

  logic [3:0] level, rise, ev;

  for (genvar g = 0; g < 4; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYC  (DEBOUNCE_CYC),
      .BTN_ACTIVE_LOW(BTN_ACTIVE_LOW)
    ) u_deb (
      .clk  (clk),
      .rst  (rst),
      .btn  (btn[g]),
      .level(level[g]),
      .rise (rise[g])
    );
  end

  assign ev = rise | (level & {4{AUTOREPEAT}});

  fsm_t          state_q, state_d;
  gesture_t      sig_q, sig_d;
  logic          start_q, start_d;
  logic [TW-1:0] timer_q, timer_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      sig_q   <= G_NONE;
      start_q <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      sig_q   <= sig_d;
      start_q <= start_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sig_d   = sig_q;
    start_d = 1'b0;
    timer_d = timer_q;
    unique case (state_q)
      IDLE: begin
        if (|ev) begin
          sig_d   = gesture_from_events(ev);
          start_d = 1'b1;
          timer_d = TW'(HOLD_CYC - 1);
          state_d = HOLD;
        end
      end
      HOLD: begin
        if (timer_q == '0) begin
          sig_d = G_NONE;
          if (COOLDOWN_CYC > 0) begin
            timer_d = TW'(CD_LOAD);
            state_d = COOLDOWN;
          end else begin
            state_d = IDLE;
          end
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      COOLDOWN: begin
        if (timer_q == '0) state_d = IDLE;
        else               timer_d = timer_q - TW'(1);
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    signal = sig_q;
    start  = start_q;
    busy   = (state_q != IDLE);
  end

endmodule

// File: tb/tb_gesture_encoder.sv
// Directed bench for gesture_encoder at 1 cycle = 1 ms (debounce 3, hold 7, cooldown 2).
module tb_gesture_encoder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] btn = 4'hF;
  logic [2:0] signal;
  logic       start;
  logic       busy;

  int checks = 0;
  int errors = 0;

  gesture_encoder #(
    .CLK_FRE       (1000),
    .DEBOUNCE_MS   (3),
    .HOLD_MS       (7),
    .COOLDOWN_MS   (2),
    .BTN_ACTIVE_LOW(1'b1)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn),
    .signal(signal),
    .start (start),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    btn = 4'hF;
    repeat (8) tick();
    for (int i = 0; i < 40 && busy; i++) tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL wait_idle: busy=%b, required 0 within bound", busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    btn = 4'hF;
    repeat (3) tick();
    checks++;
    if (signal !== 3'd0 || start !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset: signal=%0d start=%b busy=%b, required 0 0 0", signal, start, busy);
    end
    rst = 1'b0;
    tick();
  endtask

  // Press up: debounce accepts after 6 edges, code appears on the 7th.
  task automatic test_clean_press();
    btn = 4'b1011;
    for (int i = 1; i <= 6; i++) begin
      tick();
      checks++;
      if (signal !== 3'd0 || start !== 1'b0) begin
        errors++;
        $display("FAIL clean_pre cyc%0d: signal=%0d start=%b, required 0 0", i, signal, start);
      end
    end
    tick();
    checks++;
    if (signal !== 3'd3 || start !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL clean_first: signal=%0d start=%b busy=%b, required 3 1 1", signal, start, busy);
    end
    for (int i = 8; i <= 13; i++) begin
      tick();
      checks++;
      if (signal !== 3'd3 || start !== 1'b0) begin
        errors++;
        $display("FAIL clean_hold cyc%0d: signal=%0d start=%b, required 3 0", i, signal, start);
      end
    end
    tick();
    checks++;
    if (signal !== 3'd0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL clean_end: signal=%0d busy=%b, required 0 1", signal, busy);
    end
    tick();
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL clean_cool: busy=%b, required 1", busy);
    end
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL clean_idle: busy=%b, required 0", busy);
    end
`ifndef GESTURE_AUTOREPEAT_EN
    btn = 4'hF;
    for (int i = 0; i < 12; i++) begin
      tick();
      checks++;
      if (signal !== 3'd0 || start !== 1'b0) begin
        errors++;
        $display("FAIL clean_release cyc%0d: signal=%0d start=%b, required 0 0", i, signal, start);
      end
    end
`endif
    wait_idle();
  endtask

  task automatic test_glitch();
    btn = 4'b1110;
    repeat (2) tick();
    btn = 4'hF;
    for (int i = 0; i < 15; i++) begin
      tick();
      checks++;
      if (signal !== 3'd0 || start !== 1'b0) begin
        errors++;
        $display("FAIL glitch cyc%0d: signal=%0d start=%b, required 0 0", i, signal, start);
      end
    end
  endtask

  task automatic test_simultaneous();
    btn = 4'b0101;
    repeat (7) tick();
    checks++;
    if (signal !== 3'd2 || start !== 1'b1) begin
      errors++;
      $display("FAIL simultaneous: signal=%0d start=%b, required 2 1", signal, start);
    end
    wait_idle();
  endtask

  task automatic test_press_during_hold();
    btn = 4'b0111;
    repeat (7) tick();
    checks++;
    if (signal !== 3'd4 || start !== 1'b1) begin
      errors++;
      $display("FAIL hold_down: signal=%0d start=%b, required 4 1", signal, start);
    end
    btn = 4'b0110;
    for (int i = 8; i <= 13; i++) begin
      tick();
      checks++;
      if (signal !== 3'd4 || start !== 1'b0) begin
        errors++;
        $display("FAIL hold_keep cyc%0d: signal=%0d start=%b, required 4 0", i, signal, start);
      end
    end
    tick();
    checks++;
    if (signal !== 3'd0) begin
      errors++;
      $display("FAIL hold_end: signal=%0d, required 0", signal);
    end
`ifndef GESTURE_AUTOREPEAT_EN
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (signal !== 3'd0 || start !== 1'b0) begin
        errors++;
        $display("FAIL hold_discard cyc%0d: signal=%0d start=%b, required 0 0", i, signal, start);
      end
    end
`endif
    wait_idle();
  endtask

  task automatic test_reset_mid_hold();
    btn = 4'b1011;
    repeat (7) tick();
    checks++;
    if (signal !== 3'd3) begin
      errors++;
      $display("FAIL rst_hold_start: signal=%0d, required 3", signal);
    end
    repeat (3) tick();
    #1 rst = 1'b1;
    #1;
    checks++;
    if (signal !== 3'd0 || busy !== 1'b0 || start !== 1'b0) begin
      errors++;
      $display("FAIL rst_async: signal=%0d busy=%b start=%b, required 0 0 0", signal, busy, start);
    end
    btn = 4'hF;
    tick();
    rst = 1'b0;
    wait_idle();
  endtask

  task automatic test_autorepeat();
    int pulses = 0;
    int first  = 0;
    int second = 0;
    btn = 4'b0111;
    for (int i = 1; i <= 30; i++) begin
      tick();
      if (start) begin
        pulses++;
        if (pulses == 1) first = i;
        if (pulses == 2) second = i;
        checks++;
        if (signal !== 3'd4) begin
          errors++;
          $display("FAIL repeat_code cyc%0d: signal=%0d, required 4", i, signal);
        end
      end
    end
`ifdef GESTURE_AUTOREPEAT_EN
    checks++;
    if (pulses != 3 || first != 7 || second != 17) begin
      errors++;
      $display("FAIL repeat_pulses: count=%0d first=%0d second=%0d, required 3 7 17", pulses, first, second);
    end
`else
    checks++;
    if (pulses != 1 || first != 7) begin
      errors++;
      $display("FAIL single_pulse: count=%0d first=%0d, required 1 7", pulses, first);
    end
`endif
    wait_idle();
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_simultaneous();
    test_press_during_hold();
    test_reset_mid_hold();
    test_autorepeat();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/gesture_encoder.md
Name: gesture_encoder

Overview:
- Upstream stage of the wave LED display.
- Turns four raw direction buttons into the 3-bit `signal` code that selects a wave animation.
- Per button: synchronise, debounce, edge-detect.
- Resolves simultaneous presses by priority.
- Holds the chosen code for one full animation, then applies a cooldown so a new gesture cannot cut an animation short.

Parameters:
- CLK_FRE, 50000000, system clock frequency in Hz.
- DEBOUNCE_MS, 10, input must be stable this long to be accepted; DEBOUNCE_CYC = CLK_FRE/1000*DEBOUNCE_MS.
- HOLD_MS, 1400, time `signal` is held non-zero (7 animation frames at 0.2 s); must be >= 1; HOLD_CYC derived the same way.
- COOLDOWN_MS, 200, forced idle gap after a hold; 0 allowed; COOLDOWN_CYC derived the same way.
- BTN_ACTIVE_LOW, 1, 1 = pressed reads 0 on the pin; 0 = pressed reads 1.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset, asynchronous, active-high.
- btn  in  4  raw buttons; [0]=left, [1]=right, [2]=up, [3]=down; asynchronous to clk.
- signal  out  3  gesture code to the wave display: 000 none, 001 left, 010 right, 011 up, 100 down.
- start  out  1  one-cycle pulse in the cycle `signal` first takes a new non-zero code.
- busy  out  1  high in HOLD and COOLDOWN.

Behaviour:
- Reset, asserted at any time including mid-hold:
  - `signal`=000, `start`=0, `busy`=0 immediately.
  - Synchroniser flops and debounced levels = not pressed; timers = 0; state = IDLE.
- Synchroniser:
  - 2 flops per button, then polarity normalised to pressed=1.
  - Input-to-debouncer latency is 2 cycles.
- Debounce, per button:
  - Counter of width $clog2(DEBOUNCE_CYC+1).
  - Counter clears whenever the synced level equals the debounced level.
  - Otherwise it increments; when it reaches DEBOUNCE_CYC the debounced level flips and the counter clears.
  - Glitches shorter than DEBOUNCE_CYC cycles are never seen.
- Press event: debounced level rises 0->1; lasts one cycle. Releases generate nothing.
- Priority when several events occur in the same cycle: left > right > up > down.
- FSM:
  - IDLE:
    - On any event, `signal` <= code of the winner and `start` <= 1 for 1 cycle.
    - Hold timer <= HOLD_CYC-1; go to HOLD.
    - Event-to-`signal` latency: 1 cycle.
  - HOLD:
    - `signal` stays constant; timer decrements each cycle.
    - When timer = 0: `signal` <= 000.
    - If COOLDOWN_CYC > 0, load cooldown timer with COOLDOWN_CYC-1 and go to COOLDOWN; else go to IDLE.
    - `signal` is therefore non-zero for exactly HOLD_CYC cycles.
  - COOLDOWN: `signal`=000; timer decrements; at 0 go to IDLE.
- Events in HOLD or COOLDOWN are discarded, never queued.
- A button still held when IDLE is re-entered does not retrigger; only a fresh edge does.
- `start` is never high outside the IDLE->HOLD transition.
- Timer width is $clog2(max(HOLD_CYC, COOLDOWN_CYC)+1); no wrap is possible.

Optional Feature:
- Macro: GESTURE_AUTOREPEAT_EN.
- Defined:
  - In IDLE, a debounced level that is still pressed counts as an event, so a held button restarts the animation every HOLD_CYC+COOLDOWN_CYC+1 cycles.
  - Priority among held buttons follows the same order as for events.
- Undefined: edge-only behaviour as described above.

Decomposition:
- Package gesture_pkg holds:
  - typedef enum logic [2:0] gesture_t: G_NONE, G_LEFT, G_RIGHT, G_UP, G_DOWN.
  - typedef enum fsm_t: IDLE, HOLD, COOLDOWN.
  - The ms-to-cycles constant function.
- The wave display imports the same gesture_t.
- Sub-module btn_debounce:
  - One instance per button, 4 instances total.
  - Contains the synchroniser, polarity normalisation, debounce counter and rise-edge output.

Test Plan:
Bench parameters: CLK_FRE=1000 (1 cycle = 1 ms), DEBOUNCE_MS=3, HOLD_MS=7, COOLDOWN_MS=2, BTN_ACTIVE_LOW=1.
1. Clean press: drive btn[2] low at cycle 10 and hold.
   - Debounced at cycle 15, `signal`=011 and `start`=1 at cycle 16.
   - `signal` returns to 000 after 7 cycles; `busy` falls 2 cycles later.
2. Glitch: btn[0] low for 2 cycles, then high -> `signal` stays 000 and `start` never pulses.
3. Simultaneous: btn[1] and btn[3] low in the same cycle -> `signal`=010 (right wins).
4. Press during HOLD or COOLDOWN: press btn[0] during a down hold -> `signal` stays 100, then 000; no left code follows.
5. Reset mid-hold: assert `rst` 3 cycles into a hold -> `signal`=000 and `busy`=0 in the same cycle, with no clock edge needed.
6. With GESTURE_AUTOREPEAT_EN: hold btn[3] for 30 cycles -> `start` pulses every 10 cycles, `signal`=100 each time.
   - Without the macro: exactly one pulse.
